mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one start/finish-style 32x32 sequential multiplier among N requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's start, multiplicand and multiplier inputs.
- Returns the 64-bit product tagged with the requester ID over a single valid/ready response channel.
- Sits between the multiplier instance and the client units that issue multiply requests.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, equal to clog2(N_REQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept; at most one bit high
req_a  input  32*N_REQ  multiplicands, requester i at bits [32i+31:32i]
req_b  input  32*N_REQ  multipliers, same packing
resp_valid  output  1  product valid
resp_ready  input  1  consumer accepts product
resp_id  output  IDW  requester that owns resp_product
resp_product  output  64  unsigned product
busy  output  1  high in any state other than IDLE
mul_start  output  1  start pulse to multiplier
mul_a  output  32  multiplicand to multiplier
mul_b  output  32  multiplier operand to multiplier
mul_product  input  64  multiplier result
mul_finish  input  1  multiplier done; level, cleared by the multiplier on start

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, rr_ptr=0, all outputs 0.
  - Operand and response registers are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[grant]=1, combinational on req_valid; all other req_ready bits are 0. All req_ready bits are 0 outside IDLE.
  - On the accepting edge: latch req_a[grant] and req_b[grant] into op_a/op_b, latch grant into id_q, set rr_ptr=(grant+1) mod N_REQ, go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly one cycle, then go to WAIT.
  - mul_finish is ignored in this cycle, since it may be stale from the previous operation.
- WAIT:
  - mul_start=0.
  - When mul_finish=1: capture mul_product into resp_product and id_q into resp_id, go to RESP.
- RESP:
  - resp_valid=1. resp_product and resp_id stay stable until resp_valid && resp_ready.
  - On that edge go to IDLE.
  - No new grant is issued while in RESP; one bubble cycle in IDLE per transaction.
- Operand stability:
  - mul_a=op_a and mul_b=op_b continuously, from ISSUE through WAIT.
  - They are held stable during the whole multiply, because the multiplier reads the multiplicand every iteration.
- Arithmetic: product is unsigned 64-bit, passed through unmodified.
- Latency with the standard 32-iteration multiplier: resp_valid rises 35 edges after the accepting edge.
- Fairness: a continuously valid requester waits at most N_REQ-1 other transactions.
- req_valid deasserted by a requester before its grant is legal; that requester is simply not granted.
- Simultaneous events:
  - A requester is never granted twice in a row while any other requester is valid.
  - req_valid changes during ISSUE/WAIT/RESP have no effect until IDLE.
- Reset mid-operation:
  - rst_n low returns to IDLE and drops resp_valid and mul_start immediately, asynchronously.
  - The multiplier is reset in parallel by the top level; no pending transaction survives.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Single request, id 2, a=7, b=6, resp_ready=1 -> req_ready[2] pulses one cycle; mul_start one cycle; resp_valid after 35 edges with resp_id=2, resp_product=0x2A.
- All four req_valid high from reset with distinct operands -> grants in order 0,1,2,3; each response carries the correct id and product; never two mul_start pulses without an intervening mul_finish.
- Requests 0 and 3 pending after requester 1 was last served (rr_ptr=2) -> 3 granted before 0.
- a=b=0xFFFFFFFF -> resp_product=0xFFFFFFFE00000001. Also a=0, b=0x12345678 -> 0.
- resp_ready held low 10 cycles in RESP with other requests pending -> resp_valid, resp_id and resp_product stable; no req_ready asserted; on resp_ready=1 the next grant follows.
- rst_n pulsed low during WAIT -> outputs 0 at once; after release, a new request completes correctly with rr_ptr=0 priority.

Source files
------------

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one start/finish 32x32 sequential multiplier
module mul_share_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [63:0]          resp_product,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_product,
  input  logic                 mul_finish
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [31:0]    op_a_q, op_a_d;
  logic [31:0]    op_b_q, op_b_d;
  logic [63:0]    resp_prod_q, resp_prod_d;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;

  // Modulo-N_REQ increment; N_REQ need not be a power of two.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && req_valid[wrap_inc(rr_q, k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_inc(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    resp_id_d   = resp_id_q;
    resp_prod_d = resp_prod_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          op_a_d  = req_a[32*grant_idx +: 32];
          op_b_d  = req_b[32*grant_idx +: 32];
          id_d    = grant_idx;
          rr_d    = wrap_inc(grant_idx, 1);
          state_d = S_ISSUE;
        end
      end
      // mul_finish may still be high from the previous job here, so it is not looked at.
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_finish) begin
          resp_prod_d = mul_product;
          resp_id_d   = id_q;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      resp_id_q   <= '0;
      resp_prod_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      resp_id_q   <= resp_id_d;
      resp_prod_q <= resp_prod_d;
    end
  end

  // Outputs decode straight from registers so an asynchronous reset clears them at once.
  assign req_ready    = (state_q == S_IDLE && grant_vld) ? (N_REQ'(1) << grant_idx) : '0;
  assign busy         = (state_q != S_IDLE);
  assign mul_start    = (state_q == S_ISSUE);
  assign mul_a        = op_a_q;
  assign mul_b        = op_b_q;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_id      = resp_id_q;
  assign resp_product = resp_prod_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - randomized bench for mul_share_arb against a round-robin/product model
module tb_mul_share_arb;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic            resp_valid, resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [63:0]     resp_product;
  logic            busy, mul_start;
  logic [31:0]     mul_a, mul_b;
  logic [63:0]     mul_product;
  logic            mul_finish;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_share_arb #(.N_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_finish(mul_finish)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shift-add multiplier: loads on start, 32 iterations re-reading mul_a, then raises finish.
  logic [63:0] m_acc;
  logic [5:0]  m_cnt;
  logic        m_run;
  logic [32:0] m_sum;
  assign m_sum       = {1'b0, m_acc[63:32]} + (m_acc[0] ? {1'b0, mul_a} : 33'd0);
  assign mul_product = m_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= '0; m_cnt <= '0; m_run <= 1'b0; mul_finish <= 1'b0;
    end else if (mul_start) begin
      m_acc <= {32'd0, mul_b}; m_cnt <= 6'd32; m_run <= 1'b1; mul_finish <= 1'b0;
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run <= 1'b0; mul_finish <= 1'b1;
      end else begin
        m_acc <= {m_sum, m_acc[31:1]}; m_cnt <= m_cnt - 6'd1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          glog[$];
  int          rr_m;
  bit          m_idle;
  bit          prev_rv;
  int          start_due;
  int          held;
  logic [N-1:0] acc_mask;
  logic [IDW-1:0] hold_id;
  logic [63:0] hold_prod, last_prod;
  int          last_id;

  function automatic int model_grant(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : mon
    int g;
    exp_t e;
    if (!rst_n) begin
      rr_m = 0; m_idle = 1'b1; sb.delete(); prev_rv = 1'b0; start_due = -1; acc_mask = '0;
    end else begin
      g = model_grant(req_valid, rr_m);
      check("req_ready", 64'(req_ready), (m_idle && g >= 0) ? (64'd1 << g) : 64'd0);
      check("busy", 64'(busy), m_idle ? 64'd0 : 64'd1);
      check("mul_start", 64'(mul_start), (cyc == start_due) ? 64'd1 : 64'd0);
      acc_mask = req_valid & req_ready;
      if (mul_start && sb.size() > 0) begin
        check("mul_a", 64'(mul_a), 64'(sb[$].a));
        check("mul_b", 64'(mul_b), 64'(sb[$].b));
      end
      if (m_idle && g >= 0) begin
        e.id = g; e.a = req_a[32*g +: 32]; e.b = req_b[32*g +: 32];
        e.prod = 64'(e.a) * 64'(e.b); e.due = cyc + 36;
        sb.push_back(e); glog.push_back(g);
        rr_m = (g + 1) % N; m_idle = 1'b0; start_due = cyc + 1;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_spurious", 64'd1, 64'd0);
        end else begin
          if (!prev_rv) check("latency", 64'(cyc), 64'(sb[0].due));
          else begin
            check("hold_id", 64'(resp_id), 64'(hold_id));
            check("hold_prod", resp_product, hold_prod);
          end
          if (resp_ready) begin
            check("resp_id", 64'(resp_id), 64'(sb[0].id));
            check("resp_prod", resp_product, sb[0].prod);
            last_prod = resp_product; last_id = int'(resp_id);
            void'(sb.pop_front()); m_idle = 1'b1; prev_rv = 1'b0;
          end else begin
            prev_rv = 1'b1; hold_id = resp_id; hold_prod = resp_product; held++;
          end
        end
      end else if (prev_rv) begin
        check("resp_dropped", 64'd1, 64'd0);
        prev_rv = 1'b0;
      end
    end
  end

  int          cnt[N];
  logic [31:0] oa[N], ob[N];
  int          hold_left;

  task automatic step(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        cnt[i]--;
        if (rnd) begin oa[i] = $urandom; ob[i] = $urandom; end
      end
      req_valid[i] = (cnt[i] > 0) && (!rnd || $urandom_range(0, 3) != 0);
      req_a[32*i +: 32] = oa[i];
      req_b[32*i +: 32] = ob[i];
    end
    if (hold_left > 0 && resp_valid) begin
      resp_ready = 1'b0; hold_left--;
    end else begin
      resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic run(input bit rnd, input int max_cyc, output bit done);
    int pend;
    done = 1'b0;
    for (int t = 0; t < max_cyc && !done; t++) begin
      @(posedge clk); #1;
      step(rnd);
      pend = 0;
      for (int i = 0; i < N; i++) pend += cnt[i];
      if (pend == 0 && sb.size() == 0 && m_idle) done = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rv"}, 64'(resp_valid), 64'd0);
    check({tag, "_start"}, 64'(mul_start), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_prod"}, resp_product, 64'd0);
    check({tag, "_id"}, 64'(resp_id), 64'd0);
    check({tag, "_mula"}, 64'(mul_a), 64'd0);
    check({tag, "_mulb"}, 64'(mul_b), 64'd0);
  endtask

  task automatic do_reset();
    req_valid = '0; hold_left = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    hold_left = 0; held = 0; last_prod = '0; last_id = -1;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; oa[i] = '0; ob[i] = '0; end
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // single request from id 2
    oa[2] = 32'd7; ob[2] = 32'd6; cnt[2] = 1; glog.delete();
    run(1'b0, 200, done);
    check("t1_done", 64'(done), 64'd1);
    check("t1_grants", 64'(glog.size()), 64'd1);
    check("t1_id", 64'(last_id), 64'd2);
    check("t1_prod", last_prod, 64'h2A);

    // all four from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      oa[i] = 32'h1000 + 32'(i) * 32'h111; ob[i] = 32'hABCD0000 + 32'(i) * 32'h37; cnt[i] = 1;
    end
    glog.delete();
    run(1'b0, 400, done);
    check("t2_done", 64'(done), 64'd1);
    check("t2_count", 64'(glog.size()), 64'd4);
    for (int k = 0; k < glog.size() && k < 4; k++) check("t2_order", 64'(glog[k]), 64'(k));

    // requester 1 served, then 0 and 3 pending: 3 wins
    glog.delete();
    oa[1] = 32'd3; ob[1] = 32'd5; cnt[1] = 1;
    run(1'b0, 200, done);
    check("t3a_done", 64'(done), 64'd1);
    oa[0] = 32'd11; ob[0] = 32'd13; oa[3] = 32'd17; ob[3] = 32'd19; cnt[0] = 1; cnt[3] = 1;
    run(1'b0, 300, done);
    check("t3_done", 64'(done), 64'd1);
    check("t3_count", 64'(glog.size()), 64'd3);
    if (glog.size() == 3) begin
      check("t3_first", 64'(glog[1]), 64'd3);
      check("t3_second", 64'(glog[2]), 64'd0);
    end

    // operand extremes
    oa[0] = 32'hFFFFFFFF; ob[0] = 32'hFFFFFFFF; cnt[0] = 1;
    run(1'b0, 200, done);
    check("t4_max", last_prod, 64'hFFFFFFFE00000001);
    oa[0] = 32'h0; ob[0] = 32'h12345678; cnt[0] = 1;
    run(1'b0, 200, done);
    check("t4_zero", last_prod, 64'h0);
    check("t4_done", 64'(done), 64'd1);

    // back-pressure on the response with others waiting
    held = 0; hold_left = 10;
    oa[0] = 32'd100; ob[0] = 32'd200; oa[1] = 32'd300; ob[1] = 32'd400; oa[2] = 32'd9; ob[2] = 32'd9;
    cnt[0] = 1; cnt[1] = 1; cnt[2] = 1;
    run(1'b0, 400, done);
    check("t5_done", 64'(done), 64'd1);
    check("t5_held", (held >= 10) ? 64'd1 : 64'd0, 64'd1);

    // reset while the multiply is in flight
    oa[2] = 32'd55; ob[2] = 32'd66; cnt[2] = 1;
    run(1'b0, 12, done);
    req_valid = '0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_outputs_zero("t6_rst");
    for (int i = 0; i < N; i++) cnt[i] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    glog.delete();
    oa[1] = 32'd21; ob[1] = 32'd2; oa[3] = 32'd8; ob[3] = 32'd8; cnt[1] = 1; cnt[3] = 1;
    run(1'b0, 300, done);
    check("t6_done", 64'(done), 64'd1);
    check("t6_count", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) check("t6_first", 64'(glog[0]), 64'd1);

    // randomized traffic
    for (int i = 0; i < N; i++) begin
      oa[i] = $urandom; ob[i] = $urandom; cnt[i] = $urandom_range(2, 5);
    end
    run(1'b1, 6000, done);
    check("rand_done", 64'(done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
